one_wire_bit_engine: RTL

Bit-slot timing engine for the 1-Wire bus, directly downstream of `one_wire_interface`. The interface sequences ROM and function commands. This block turns each request into exact bus waveforms: reset/presence, write-0, write-1/read slots, and 8-slot byte transfers. It drives the open-drain pad through `data_out`/`data_oe` and samples `data_in`. It returns presence, read bits and bytes on a single-cycle response strobe.

---
 rtl/one_wire_bit_engine_if.sv | 29 ++
 rtl/one_wire_bit_engine.sv | 129 ++++++++++++
 2 files changed

// File: rtl/one_wire_bit_engine_if.sv
// Command/response handshake and open-drain pad signals between the
// 1-Wire command sequencer (master) and the bit-slot engine (slave).
interface one_wire_bit_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       tx_bit;
  logic [7:0] tx_byte;
  logic       rsp_valid;
  logic       rsp_bit;
  logic [7:0] rsp_byte;
  logic       presence;
  logic       rsp_err;
  logic       data_in;
  logic       data_out;
  logic       data_oe;

  modport master (
    output cmd_valid, cmd_op, tx_bit, tx_byte, data_in,
    input  cmd_ready, rsp_valid, rsp_bit, rsp_byte, presence, rsp_err,
           data_out, data_oe
  );

  modport slave (
    input  cmd_valid, cmd_op, tx_bit, tx_byte, data_in,
    output cmd_ready, rsp_valid, rsp_bit, rsp_byte, presence, rsp_err,
           data_out, data_oe
  );
endinterface

// File: rtl/one_wire_bit_engine.sv
// 1-Wire bit-slot engine: turns reset / bit / byte requests into exact
// open-drain bus waveforms and returns presence, sampled bits and bytes.
module one_wire_bit_engine #(
  parameter int CLKS_PER_US = 50
) (
  input logic                  clk,
  input logic                  rst_n,
  one_wire_bit_engine_if.slave bus
);
  localparam int N  = CLKS_PER_US;
  localparam int CW = $clog2(480 * N) + 1;
  typedef logic [CW-1:0] cnt_t;

  // Terminal counts are "length - 1": the counter restarts at 0 on phase entry.
  localparam cnt_t RST_END    = cnt_t'(480 * N - 1);
  localparam cnt_t PRES_AT    = cnt_t'(70 * N - 1);
  localparam cnt_t W0_LOW_END = cnt_t'(60 * N - 1);
  localparam cnt_t W0_REL_END = cnt_t'(10 * N - 1);
  localparam cnt_t W1_LOW_END = cnt_t'(6 * N - 1);
  localparam cnt_t W1_REL_END = cnt_t'(64 * N - 1);
  localparam cnt_t W0_SAMP    = cnt_t'(15 * N - 1);
  localparam cnt_t W1_SAMP    = cnt_t'(9 * N - 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL
  } state_t;

  state_t     state;
  cnt_t       cnt;
  logic [1:0] sync;
  logic       oe, ready, rvld, rbit, pres, err, samp, is_byte;
  logic [7:0] rbyte, tx_sh, rx_sh;
  logic [2:0] slots_left;

  // tx_sh[0] is the type of the slot in flight: 1 = write-1/read, 0 = write-0.
  wire slot_one = tx_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sync       <= 2'b11;
      oe         <= 1'b0;
      ready      <= 1'b1;
      rvld       <= 1'b0;
      rbit       <= 1'b0;
      rbyte      <= 8'h00;
      pres       <= 1'b0;
      err        <= 1'b0;
      samp       <= 1'b0;
      is_byte    <= 1'b0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      slots_left <= 3'd0;
    end else begin
      sync <= {sync[0], bus.data_in};
      rvld <= 1'b0;
      if (state != IDLE) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (bus.cmd_valid && ready) begin
          cnt        <= '0;
          oe         <= 1'b1;
          ready      <= 1'b0;
          is_byte    <= (bus.cmd_op == 2'd3);
          slots_left <= (bus.cmd_op == 2'd3) ? 3'd7 : 3'd0;
          case (bus.cmd_op)
            2'd0:    tx_sh <= 8'h00;
            2'd1:    tx_sh <= {7'd0, bus.tx_bit};
            2'd2:    tx_sh <= 8'h01;
            default: tx_sh <= bus.tx_byte;
          endcase
          state <= (bus.cmd_op == 2'd0) ? RST_LOW : SLOT_LOW;
        end
        RST_LOW: if (cnt == RST_END) begin
          state <= RST_REL;
          cnt   <= '0;
          oe    <= 1'b0;
        end
        RST_REL: begin
          if (cnt == PRES_AT) pres <= ~sync[1];
          if (cnt == RST_END) begin
            state <= IDLE;
            ready <= 1'b1;
            rvld  <= 1'b1;
            err   <= ~sync[1];
          end
        end
        SLOT_LOW: begin
          // A write-0 slot reaches its sample point while still driving low.
          if (!slot_one && cnt == W0_SAMP) samp <= sync[1];
          if (cnt == (slot_one ? W1_LOW_END : W0_LOW_END)) begin
            state <= SLOT_REL;
            cnt   <= '0;
            oe    <= 1'b0;
          end
        end
        SLOT_REL: begin
          if (slot_one && cnt == W1_SAMP) samp <= sync[1];
          if (cnt == (slot_one ? W1_REL_END : W0_REL_END)) begin
            if (slots_left == 3'd0) begin
              state <= IDLE;
              ready <= 1'b1;
              rvld  <= 1'b1;
              if (is_byte) rbyte <= {samp, rx_sh[7:1]};
              else         rbit  <= samp;
            end else begin
              slots_left <= slots_left - 1'b1;
              tx_sh      <= {1'b0, tx_sh[7:1]};
              rx_sh      <= {samp, rx_sh[7:1]};
              state      <= SLOT_LOW;
              cnt        <= '0;
              oe         <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rvld;
  assign bus.rsp_bit   = rbit;
  assign bus.rsp_byte  = rbyte;
  assign bus.presence  = pres;
  assign bus.rsp_err   = err;
  assign bus.data_oe   = oe;
  assign bus.data_out  = ~oe;
endmodule
